// File: rtl/xz_operand_mux_syncrst_pkg.sv
// Shared constants and select encodings for the X/Z operand-select stage.
package xz_operand_mux_syncrst_pkg;

    localparam int unsigned OUT_W     = 48;
    localparam int unsigned M_W       = 36;
    localparam int unsigned AB_W      = 18;
    localparam int unsigned D_SLICE_W = 12;

    // OPMODE bit positions used by this stage
    localparam int unsigned OPM_SUB_BIT = 7;
    localparam int unsigned OPM_CIN_BIT = 5;
    localparam int unsigned OPM_Z_HI    = 3;
    localparam int unsigned OPM_Z_LO    = 2;
    localparam int unsigned OPM_X_HI    = 1;
    localparam int unsigned OPM_X_LO    = 0;

    typedef enum logic [1:0] {
        X_ZERO = 2'b00,
        X_M    = 2'b01,
        X_P    = 2'b10,
        X_DAB  = 2'b11
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'b00,
        Z_PCIN = 2'b01,
        Z_P    = 2'b10,
        Z_C    = 2'b11
    } z_sel_e;

endpackage

// File: rtl/xz_operand_mux_syncrst_if.sv
// Operand/control bundle between the upstream driver and the X/Z select stage.
interface xz_operand_mux_syncrst_if #(
    parameter int unsigned OUT_WIDTH = xz_operand_mux_syncrst_pkg::OUT_W,
    parameter int unsigned M_WIDTH   = xz_operand_mux_syncrst_pkg::M_W,
    parameter int unsigned AB_WIDTH  = xz_operand_mux_syncrst_pkg::AB_W
);
    logic                 CEM;
    logic                 CEC;
    logic                 CEOPMODE;
    logic                 CEDAB;
    logic [7:0]           OPMODE;
    logic [M_WIDTH-1:0]   M;
    logic [OUT_WIDTH-1:0] C;
    logic [OUT_WIDTH-1:0] PCIN;
    logic [OUT_WIDTH-1:0] P;
    logic [AB_WIDTH-1:0]  D;
    logic [AB_WIDTH-1:0]  A;
    logic [AB_WIDTH-1:0]  B;
    logic [OUT_WIDTH-1:0] X;
    logic [OUT_WIDTH-1:0] Z;
    logic                 opmode_5;
    logic                 opmode_7;

    modport master (
        output CEM, CEC, CEOPMODE, CEDAB, OPMODE, M, C, PCIN, P, D, A, B,
        input  X, Z, opmode_5, opmode_7
    );

    modport slave (
        input  CEM, CEC, CEOPMODE, CEDAB, OPMODE, M, C, PCIN, P, D, A, B,
        output X, Z, opmode_5, opmode_7
    );

endinterface

// File: rtl/xz_operand_mux_syncrst_mux_syncrst.sv
// MUX_SYNCRST: register-with-enable (sync active-high reset) or pure wire, chosen by sel.
module MUX_SYNCRST #(
    parameter int unsigned data_width = 1,
    parameter int unsigned sel        = 1
) (
    input  logic [data_width-1:0] in,
    output logic [data_width-1:0] out,
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  C_ENABLE
);

    if (sel != 0) begin : g_reg
        logic [data_width-1:0] data_q;
        logic [data_width-1:0] data_d;

        // Next state: load on enable, otherwise hold
        always_comb begin
            data_d = data_q;
            if (C_ENABLE) begin
                data_d = in;
            end
        end

        // State register; reset overrides the enable
        always_ff @(posedge CLK) begin
            if (rst) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign out = data_q;
    end else begin : g_bypass
        logic unused_bypass;

        assign out = in;
        assign unused_bypass = ^{CLK, rst, C_ENABLE};
    end

endmodule

// File: rtl/xz_operand_mux_syncrst.sv
// X/Z operand-select stage feeding the post-adder.
// Optional feature: define XZ_DAB_CONCAT_EN to enable the D:A:B concatenation on X select 11
// (and its D/A/B registers); otherwise that select yields 0 and D/A/B/CEDAB are ignored.
module xz_operand_mux_syncrst
    import xz_operand_mux_syncrst_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = OUT_W,
    parameter int unsigned M_WIDTH   = M_W,
    parameter int unsigned AB_WIDTH  = AB_W,
    parameter int unsigned MREG      = 1,
    parameter int unsigned CREG      = 1,
    parameter int unsigned OPMODEREG = 1,
    parameter int unsigned DABREG    = 1
) (
    input logic                    CLK,
    input logic                    rst,
    xz_operand_mux_syncrst_if.slave xz_bus
);

    logic [M_WIDTH-1:0]   m_eff;
    logic [OUT_WIDTH-1:0] c_eff;
    logic [7:0]           opmode_eff;
    logic [OUT_WIDTH-1:0] dab_cat;
    x_sel_e               x_sel;
    z_sel_e               z_sel;

    MUX_SYNCRST #(.data_width(M_WIDTH), .sel(MREG)) u_m_reg (
        .in(xz_bus.M), .out(m_eff), .CLK(CLK), .rst(rst), .C_ENABLE(xz_bus.CEM)
    );

    MUX_SYNCRST #(.data_width(OUT_WIDTH), .sel(CREG)) u_c_reg (
        .in(xz_bus.C), .out(c_eff), .CLK(CLK), .rst(rst), .C_ENABLE(xz_bus.CEC)
    );

    MUX_SYNCRST #(.data_width(8), .sel(OPMODEREG)) u_opmode_reg (
        .in(xz_bus.OPMODE), .out(opmode_eff), .CLK(CLK), .rst(rst),
        .C_ENABLE(xz_bus.CEOPMODE)
    );

`ifdef XZ_DAB_CONCAT_EN
    logic [AB_WIDTH-1:0] d_eff;
    logic [AB_WIDTH-1:0] a_eff;
    logic [AB_WIDTH-1:0] b_eff;
    logic                unused_d_hi;

    MUX_SYNCRST #(.data_width(AB_WIDTH), .sel(DABREG)) u_d_reg (
        .in(xz_bus.D), .out(d_eff), .CLK(CLK), .rst(rst), .C_ENABLE(xz_bus.CEDAB)
    );

    MUX_SYNCRST #(.data_width(AB_WIDTH), .sel(DABREG)) u_a_reg (
        .in(xz_bus.A), .out(a_eff), .CLK(CLK), .rst(rst), .C_ENABLE(xz_bus.CEDAB)
    );

    MUX_SYNCRST #(.data_width(AB_WIDTH), .sel(DABREG)) u_b_reg (
        .in(xz_bus.B), .out(b_eff), .CLK(CLK), .rst(rst), .C_ENABLE(xz_bus.CEDAB)
    );

    // Only the low D_SLICE_W bits of D reach the concatenation
    assign unused_d_hi = ^d_eff[AB_WIDTH-1:D_SLICE_W];
    assign dab_cat     = OUT_WIDTH'({d_eff[D_SLICE_W-1:0], a_eff, b_eff});
`else
    logic unused_dab;

    assign unused_dab = ^{xz_bus.D, xz_bus.A, xz_bus.B, xz_bus.CEDAB, DABREG[0]};
    assign dab_cat    = '0;
`endif

    logic unused_opmode;
    assign unused_opmode = ^{opmode_eff[6], opmode_eff[4]};

    assign x_sel = x_sel_e'(opmode_eff[OPM_X_HI:OPM_X_LO]);
    assign z_sel = z_sel_e'(opmode_eff[OPM_Z_HI:OPM_Z_LO]);

    // X operand select
    always_comb begin
        xz_bus.X = '0;
        unique case (x_sel)
            X_ZERO: xz_bus.X = '0;
            X_M:    xz_bus.X = {{(OUT_WIDTH - M_WIDTH){1'b0}}, m_eff};
            X_P:    xz_bus.X = xz_bus.P;
            X_DAB:  xz_bus.X = dab_cat;
            default: xz_bus.X = '0;
        endcase
    end

    // Z operand select
    always_comb begin
        xz_bus.Z = '0;
        unique case (z_sel)
            Z_ZERO: xz_bus.Z = '0;
            Z_PCIN: xz_bus.Z = xz_bus.PCIN;
            Z_P:    xz_bus.Z = xz_bus.P;
            Z_C:    xz_bus.Z = c_eff;
            default: xz_bus.Z = '0;
        endcase
    end

    assign xz_bus.opmode_5 = opmode_eff[OPM_CIN_BIT];
    assign xz_bus.opmode_7 = opmode_eff[OPM_SUB_BIT];

endmodule

// File: tb/tb_xz_operand_mux_syncrst.sv
// Bench for xz_operand_mux_syncrst: one all-registered instance and one all-bypassed instance,
// both fed from the same stimulus and checked against a behavioural model.
module tb_xz_operand_mux_syncrst;

    logic        clk = 1'b0;
    logic        rst;
    logic        cem, cec, ceopmode, cedab;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] c, pcin, p;
    logic [17:0] d, a, b;

    // Model of the registered copies held by the all-registered instance
    logic [7:0]  opm_r;
    logic [35:0] m_r;
    logic [47:0] c_r;
    logic [17:0] d_r, a_r, b_r;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    xz_operand_mux_syncrst_if if_a ();
    xz_operand_mux_syncrst_if if_b ();

    assign if_a.CEM = cem;      assign if_b.CEM = cem;
    assign if_a.CEC = cec;      assign if_b.CEC = cec;
    assign if_a.CEOPMODE = ceopmode; assign if_b.CEOPMODE = ceopmode;
    assign if_a.CEDAB = cedab;  assign if_b.CEDAB = cedab;
    assign if_a.OPMODE = opmode; assign if_b.OPMODE = opmode;
    assign if_a.M = m;          assign if_b.M = m;
    assign if_a.C = c;          assign if_b.C = c;
    assign if_a.PCIN = pcin;    assign if_b.PCIN = pcin;
    assign if_a.P = p;          assign if_b.P = p;
    assign if_a.D = d;          assign if_b.D = d;
    assign if_a.A = a;          assign if_b.A = a;
    assign if_a.B = b;          assign if_b.B = b;

    xz_operand_mux_syncrst dut_a (
        .CLK(clk), .rst(rst), .xz_bus(if_a.slave)
    );

    xz_operand_mux_syncrst #(
        .MREG(0), .CREG(0), .OPMODEREG(0), .DABREG(0)
    ) dut_b (
        .CLK(clk), .rst(rst), .xz_bus(if_b.slave)
    );

    function automatic logic [47:0] exp_x(logic [7:0] opm, logic [35:0] mm, logic [47:0] pp,
                                          logic [17:0] dd, logic [17:0] aa, logic [17:0] bb);
        logic [47:0] r;
        case (opm[1:0])
            2'd0: r = 48'd0;
            2'd1: r = 48'(mm);
            2'd2: r = pp;
`ifdef XZ_DAB_CONCAT_EN
            default: r = {dd[11:0], aa, bb};
`else
            default: r = 48'd0;
`endif
        endcase
        return r;
    endfunction

    function automatic logic [47:0] exp_z(logic [7:0] opm, logic [47:0] cc, logic [47:0] pc,
                                          logic [47:0] pp);
        logic [47:0] r;
        case (opm[3:2])
            2'd0: r = 48'd0;
            2'd1: r = pc;
            2'd2: r = pp;
            default: r = cc;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare the registered instance against the model
    task automatic check_a(input string tag);
        check({tag, ".X"}, if_a.X, exp_x(opm_r, m_r, p, d_r, a_r, b_r));
        check({tag, ".Z"}, if_a.Z, exp_z(opm_r, c_r, pcin, p));
        check({tag, ".op5"}, 48'(if_a.opmode_5), 48'(opm_r[5]));
        check({tag, ".op7"}, 48'(if_a.opmode_7), 48'(opm_r[7]));
    endtask

    // Compare the bypassed instance against the raw inputs
    task automatic check_b(input string tag);
        check({tag, ".bX"}, if_b.X, exp_x(opmode, m, p, d, a, b));
        check({tag, ".bZ"}, if_b.Z, exp_z(opmode, c, pcin, p));
        check({tag, ".bop5"}, 48'(if_b.opmode_5), 48'(opmode[5]));
        check({tag, ".bop7"}, 48'(if_b.opmode_7), 48'(opmode[7]));
    endtask

    // One clock edge: update the model with what the flops see, then settle
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            opm_r = '0; m_r = '0; c_r = '0; d_r = '0; a_r = '0; b_r = '0;
        end else begin
            if (ceopmode) opm_r = opmode;
            if (cem) m_r = m;
            if (cec) c_r = c;
            if (cedab) begin
                d_r = d; a_r = a; b_r = b;
            end
        end
        #1;
    endtask

    initial begin
        logic [47:0] z_tbl [4];
        z_tbl[0] = 48'h0;
        z_tbl[1] = 48'hAAAA_AAAA_AAAA;
        z_tbl[2] = 48'h5555_5555_5555;
        z_tbl[3] = 48'h1234_5678_9ABC;

        opm_r = '0; m_r = '0; c_r = '0; d_r = '0; a_r = '0; b_r = '0;
        rst = 1'b1; cem = 1'b1; cec = 1'b1; ceopmode = 1'b1; cedab = 1'b1;
        opmode = 8'hFF;
        m = 36'h9_8765_4321; c = 48'hDEAD_BEEF_0001; pcin = 48'h0102_0304_0506;
        p = 48'hCAFE_F00D_1234; d = 18'h1_2345; a = 18'h2_3456; b = 18'h3_4567;
        #2;

        // Reset with everything enabled and all-ones OPMODE
        tick();
        tick();
        check("rst.X", if_a.X, 48'h0);
        check("rst.Z", if_a.Z, 48'h0);
        check("rst.op5", 48'(if_a.opmode_5), 48'h0);
        check("rst.op7", 48'(if_a.opmode_7), 48'h0);

        // M path and hold
        rst = 1'b0; cec = 1'b0; cedab = 1'b0;
        m = 36'hF_FFFF_FFFF; opmode = 8'h01;
        tick();
        check("mpath.X", if_a.X, 48'h000F_FFFF_FFFF);
        check("mpath.Z", if_a.Z, 48'h0);
        cem = 1'b0; m = 36'h0;
        tick();
        check("mhold.X", if_a.X, 48'h000F_FFFF_FFFF);
        check_a("mhold");

        // Z source stepping
        cec = 1'b1;
        c = 48'h1234_5678_9ABC; pcin = 48'hAAAA_AAAA_AAAA; p = 48'h5555_5555_5555;
        for (int i = 0; i < 4; i++) begin
            opmode = {4'b0, 2'(i), 2'b00};
            tick();
            check($sformatf("zsel%0d", i), if_a.Z, z_tbl[i]);
        end

        // D:A:B concatenation
        cedab = 1'b1;
        d = 18'h3_0ABC; a = 18'h2_AAAA; b = 18'h1_5555; opmode = 8'h03;
        tick();
`ifdef XZ_DAB_CONCAT_EN
        check("dab.X", if_a.X, {12'hABC, 18'h2AAAA, 18'h15555});
`else
        check("dab.X", if_a.X, 48'h0);
`endif

        // Enables low: registers hold, P/PCIN still propagate
        opmode = 8'hA9;
        tick();
        cem = 1'b0; cec = 1'b0; ceopmode = 1'b0; cedab = 1'b0;
        opmode = 8'h00; p = 48'h0F0F_0F0F_0F0F;
        #1;
        check("hold.Z", if_a.Z, 48'h0F0F_0F0F_0F0F);
        check("hold.op5", 48'(if_a.opmode_5), 48'h1);
        check("hold.op7", 48'(if_a.opmode_7), 48'h1);
        tick();
        check_a("hold");

        // Reset priority over enable
        rst = 1'b1; cec = 1'b1; ceopmode = 1'b1;
        c = 48'hFFFF_FFFF_FFFF; opmode = 8'h0C;
        tick();
        check("rstpri.Z", if_a.Z, 48'h0);
        rst = 1'b0;
        tick();
        check("rstrel.Z", if_a.Z, 48'hFFFF_FFFF_FFFF);

        // Bypass instance: same-cycle follow, rst ignored
        rst = 1'b1; opmode = 8'h8C; c = 48'h1111_2222_3333;
        #1;
        check("byp.Z", if_b.Z, 48'h1111_2222_3333);
        check("byp.op7", 48'(if_b.opmode_7), 48'h1);
        c = 48'h4444_5555_6666; opmode = 8'h0D; m = 36'h1_2345_6789;
        #1;
        check("byp2.Z", if_b.Z, 48'h4444_5555_6666);
        check("byp2.X", if_b.X, 48'h0001_2345_6789);
        check("byp2.op7", 48'(if_b.opmode_7), 48'h0);
        tick();
        check_b("byprst");

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(15) == 0);
            cem      = 1'($urandom);
            cec      = 1'($urandom);
            ceopmode = 1'($urandom);
            cedab    = 1'($urandom);
            opmode   = 8'($urandom);
            m        = 36'({$urandom, $urandom});
            c        = 48'({$urandom, $urandom});
            pcin     = 48'({$urandom, $urandom});
            p        = 48'({$urandom, $urandom});
            d        = 18'($urandom);
            a        = 18'($urandom);
            b        = 18'($urandom);
            #1;
            check_b("rnd");
            tick();
            check_a("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
